// File: rtl/fixed_point_neuron_mac_if.sv
// Signal bundle for fixed_point_neuron_mac: evaluation start and bias, the X/W
// operand stream, and the pre-activation result strobe.
interface fixed_point_neuron_mac_if #(
   parameter int WIDTH = 16
);
   // Handshake: a pair moves on a rising CLK edge where VALID_IN and READY_OUT are
   // both high. The producer holds X_IN/W_IN stable while VALID_IN is high and
   // READY_OUT is low. VALID_IN may drop between pairs. VALID_OUT is a one-cycle
   // strobe with no back-pressure.
   logic             START;
   logic [WIDTH-1:0] BIAS_IN;
   logic [WIDTH-1:0] X_IN;
   logic [WIDTH-1:0] W_IN;
   logic             VALID_IN;
   logic             READY_OUT;
   logic [WIDTH-1:0] VALUE_OUT;
   logic             VALID_OUT;
   logic             OVERFLOW;

   modport master (
      output START, BIAS_IN, X_IN, W_IN, VALID_IN,
      input  READY_OUT, VALUE_OUT, VALID_OUT, OVERFLOW
   );

   modport slave (
      input  START, BIAS_IN, X_IN, W_IN, VALID_IN,
      output READY_OUT, VALUE_OUT, VALID_OUT, OVERFLOW
   );
endinterface

// File: rtl/fixed_point_neuron_mac.sv
// Fixed-point neuron MAC: sums NUM_INPUTS X*W products plus a bias, narrowed to WIDTH.
// Define FIXED_POINT_NEURON_SATURATION_EN to clamp out-of-range values (default: wrap).
module fixed_point_neuron_mac #(
   parameter int WIDTH      = 16,
   parameter int FRAC_BITS  = 13,
   parameter int NUM_INPUTS = 8
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   fixed_point_neuron_mac_if.slave bus,
   output logic [1:0]              state_dbg
);
   localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
   localparam int ACC_W  = WIDTH + CNT_W + 1;
   localparam int PROD_W = 2 * WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_BIAS  = 2'd2;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

`ifdef FIXED_POINT_NEURON_SATURATION_EN
   localparam logic [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [1:0]              state;
   logic [CNT_W-1:0]        pair_cnt;
   logic signed [ACC_W-1:0] acc;
   logic [WIDTH-1:0]        bias_q;
   logic                    ready_q;
   logic                    valid_q;
   logic                    ovf_q;
   logic [WIDTH-1:0]        value_q;

   logic signed [PROD_W-1:0] x_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] prod_full;
   logic signed [PROD_W-1:0] prod_shift;
   logic                     prod_ovf;
   logic [WIDTH-1:0]         prod_nar;
   logic signed [ACC_W-1:0]  prod_acc;
   logic signed [ACC_W-1:0]  sum;
   logic                     sum_ovf;
   logic [WIDTH-1:0]         sum_nar;
   logic                     accept;

   // ready_q is high only in ACCUM, so it alone qualifies the handshake
   assign accept = ready_q & bus.VALID_IN;

   // Product path: full-width multiply, floor shift, then narrow to WIDTH
   always_comb begin
      x_ext      = {{WIDTH{bus.X_IN[WIDTH-1]}}, bus.X_IN};
      w_ext      = {{WIDTH{bus.W_IN[WIDTH-1]}}, bus.W_IN};
      prod_full  = x_ext * w_ext;
      prod_shift = prod_full >>> FRAC_BITS;
      prod_ovf   = ~((&prod_shift[PROD_W-1:WIDTH-1]) | ~(|prod_shift[PROD_W-1:WIDTH-1]));
`ifdef FIXED_POINT_NEURON_SATURATION_EN
      if (prod_ovf) begin
         prod_nar = prod_shift[PROD_W-1] ? VAL_MIN : VAL_MAX;
      end else begin
         prod_nar = prod_shift[WIDTH-1:0];
      end
`else
      prod_nar = prod_shift[WIDTH-1:0];
`endif
      prod_acc = {{(ACC_W-WIDTH){prod_nar[WIDTH-1]}}, prod_nar};
   end

   // Result path: accumulator plus bias, narrowed the same way as a product
   always_comb begin
      sum     = acc + {{(ACC_W-WIDTH){bias_q[WIDTH-1]}}, bias_q};
      sum_ovf = ~((&sum[ACC_W-1:WIDTH-1]) | ~(|sum[ACC_W-1:WIDTH-1]));
`ifdef FIXED_POINT_NEURON_SATURATION_EN
      if (sum_ovf) begin
         sum_nar = sum[ACC_W-1] ? VAL_MIN : VAL_MAX;
      end else begin
         sum_nar = sum[WIDTH-1:0];
      end
`else
      sum_nar = sum[WIDTH-1:0];
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state    <= S_IDLE;
         pair_cnt <= '0;
         acc      <= '0;
         bias_q   <= '0;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         value_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.START) begin
                  bias_q   <= bus.BIAS_IN;
                  acc      <= '0;
                  pair_cnt <= '0;
                  ovf_q    <= 1'b0;
                  ready_q  <= 1'b1;
                  state    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc      <= acc + prod_acc;
                  pair_cnt <= pair_cnt + CNT_W'(1);
                  if (prod_ovf) begin
                     ovf_q <= 1'b1;
                  end
                  if (pair_cnt == LAST_IDX) begin
                     ready_q <= 1'b0;
                     state   <= S_BIAS;
                  end
               end
            end
            S_BIAS: begin
               value_q <= sum_nar;
               valid_q <= 1'b1;
               if (sum_ovf) begin
                  ovf_q <= 1'b1;
               end
               state <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.READY_OUT = ready_q;
   assign bus.VALUE_OUT = value_q;
   assign bus.VALID_OUT = valid_q;
   assign bus.OVERFLOW  = ovf_q;
   assign state_dbg     = state;
endmodule

// File: tb/tb_fixed_point_neuron_mac.sv
// Bench for fixed_point_neuron_mac: an 8-input instance checked every cycle against a
// transaction-level model, plus a 1-input instance for single-pair corner cases.
module tb_fixed_point_neuron_mac;
   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fixed_point_neuron_mac_if #(.WIDTH(W)) bus8 ();
   fixed_point_neuron_mac_if #(.WIDTH(W)) bus1 ();
   logic [1:0] st8;
   logic [1:0] st1;

   fixed_point_neuron_mac #(.WIDTH(W), .FRAC_BITS(13), .NUM_INPUTS(8)) dut8 (
      .CLK(clk), .RSTN(rstn), .bus(bus8), .state_dbg(st8)
   );
   fixed_point_neuron_mac #(.WIDTH(W), .FRAC_BITS(13), .NUM_INPUTS(1)) dut1 (
      .CLK(clk), .RSTN(rstn), .bus(bus1), .state_dbg(st1)
   );

   int checks = 0;
   int errors = 0;

`ifdef FIXED_POINT_NEURON_SATURATION_EN
   localparam logic [15:0] SUM_OVF_EXP  = 16'h7FFF;
   localparam logic [15:0] PROD_OVF_EXP = 16'h7FFF;
`else
   localparam logic [15:0] SUM_OVF_EXP  = 16'h8000;
   localparam logic [15:0] PROD_OVF_EXP = 16'h0000;
`endif

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout at %0t", name, $time);
   endtask

   // ---------------- behavioural model of the 8-input instance ----------------
   function automatic bit fits(input longint v);
      return (v >= -32768) && (v <= 32767);
   endfunction

   function automatic logic [15:0] narrow(input longint v);
`ifdef FIXED_POINT_NEURON_SATURATION_EN
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
`endif
      return v[15:0];
   endfunction

   function automatic longint product(input logic [15:0] x, input logic [15:0] w);
      longint p;
      p = longint'($signed(x)) * longint'($signed(w));
      return p >>> 13;
   endfunction

   bit          chk_en = 1'b0;
   bit          m_busy, m_ready, m_valid, m_ovf, m_pend;
   int          m_rem;
   longint      m_acc, m_bias, m_p, m_s;
   logic [15:0] m_value;

   always @(posedge clk) begin
      if (!rstn) begin
         m_busy = 0; m_ready = 0; m_valid = 0; m_ovf = 0; m_pend = 0;
         m_rem = 0; m_acc = 0; m_bias = 0; m_value = 16'h0000;
         chk_en = 1'b1;
      end else begin
         m_valid = 0;
         if (m_pend) begin
            m_s = m_acc + m_bias;
            if (!fits(m_s)) m_ovf = 1;
            m_value = narrow(m_s);
            m_valid = 1;
            m_pend  = 0;
            m_busy  = 0;
         end else if (!m_busy) begin
            if (bus8.START === 1'b1) begin
               m_busy = 1; m_ready = 1; m_rem = 8; m_acc = 0; m_ovf = 0;
               m_bias = longint'($signed(bus8.BIAS_IN));
            end
         end else if (m_ready && bus8.VALID_IN === 1'b1) begin
            m_p = product(bus8.X_IN, bus8.W_IN);
            if (!fits(m_p)) m_ovf = 1;
            m_acc = m_acc + longint'($signed(narrow(m_p)));
            m_rem--;
            if (m_rem == 0) begin
               m_ready = 0;
               m_pend  = 1;
            end
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready8", 16'(bus8.READY_OUT), 16'(m_ready));
         chk("valid8", 16'(bus8.VALID_OUT), 16'(m_valid));
         chk("value8", bus8.VALUE_OUT, m_value);
         chk("ovf8", 16'(bus8.OVERFLOW), 16'(m_ovf));
      end
   end

   int hs8 = 0;
   int vo8 = 0;
   always @(posedge clk) if (rstn === 1'b1 && bus8.VALID_IN === 1'b1 && bus8.READY_OUT === 1'b1) hs8++;
   always @(negedge clk) if (bus8.VALID_OUT === 1'b1) vo8++;

   // ---------------- drivers ----------------
   logic [15:0] xv[8];
   logic [15:0] wv[8];

   task automatic fill(input logic [15:0] x, input logic [15:0] w);
      for (int i = 0; i < 8; i++) begin
         xv[i] = x;
         wv[i] = w;
      end
   endtask

   task automatic run8(input logic [15:0] bias, input bit gaps, input bit mid_start, input int npairs);
      int n;
      int g;
      @(negedge clk);
      bus8.START = 1'b1;
      bus8.BIAS_IN = bias;
      if (gaps) begin
         bus8.VALID_IN = 1'b1;
         bus8.X_IN = 16'h7FFF;
         bus8.W_IN = 16'h7FFF;
      end
      @(negedge clk);
      bus8.START = 1'b0;
      bus8.VALID_IN = 1'b0;
      for (int i = 0; i < npairs; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            if (mid_start && i == 4 && g == 0) g = 1;
            for (int k = 0; k < g; k++) begin
               bus8.START = (mid_start && i == 4 && k == 0);
               bus8.VALID_IN = 1'b0;
               @(negedge clk);
            end
            bus8.START = 1'b0;
         end
         bus8.X_IN = xv[i];
         bus8.W_IN = wv[i];
         bus8.VALID_IN = 1'b1;
         n = 0;
         while (bus8.READY_OUT !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) begin
            timeout_fail("ready8_wait");
            bus8.VALID_IN = 1'b0;
            return;
         end
         @(negedge clk);
      end
      bus8.VALID_IN = 1'b0;
   endtask

   task automatic run1(input logic [15:0] bias, input logic [15:0] x, input logic [15:0] w);
      int n;
      @(negedge clk);
      bus1.START = 1'b1;
      bus1.BIAS_IN = bias;
      @(negedge clk);
      bus1.START = 1'b0;
      bus1.X_IN = x;
      bus1.W_IN = w;
      bus1.VALID_IN = 1'b1;
      n = 0;
      while (bus1.READY_OUT !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) timeout_fail("ready1_wait");
      @(negedge clk);
      bus1.VALID_IN = 1'b0;
   endtask

   // Waits for the result strobe; exp_lat is the number of negedges after the driver returns
   task automatic wait_res(input bit sel, input logic [15:0] exp_v, input bit exp_o,
                           input int exp_lat, input string name);
      int n;
      bit got;
      n = 0;
      got = 0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if ((sel ? bus1.VALID_OUT : bus8.VALID_OUT) === 1'b1) got = 1;
      end
      if (!got) begin
         timeout_fail({name, "_valid"});
      end else begin
         chk({name, "_value"}, sel ? bus1.VALUE_OUT : bus8.VALUE_OUT, exp_v);
         chk({name, "_ovf"}, 16'(sel ? bus1.OVERFLOW : bus8.OVERFLOW), 16'(exp_o));
         if (exp_lat > 0) chk({name, "_latency"}, 16'(n), 16'(exp_lat));
         @(negedge clk);
         chk({name, "_strobe_len"}, 16'(sel ? bus1.VALID_OUT : bus8.VALID_OUT), 16'h0000);
      end
   endtask

   // ---------------- directed sequence ----------------
   int hs0, vo0;

   initial begin
      rstn = 1'b0;
      bus8.START = 0; bus8.BIAS_IN = 0; bus8.X_IN = 0; bus8.W_IN = 0; bus8.VALID_IN = 0;
      bus1.START = 0; bus1.BIAS_IN = 0; bus1.X_IN = 0; bus1.W_IN = 0; bus1.VALID_IN = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready1", 16'(bus1.READY_OUT), 16'h0000);
      chk("rst_valid1", 16'(bus1.VALID_OUT), 16'h0000);
      chk("rst_value1", bus1.VALUE_OUT, 16'h0000);
      chk("rst_ovf1", 16'(bus1.OVERFLOW), 16'h0000);
      rstn = 1'b1;
      @(negedge clk);

      // nominal: 8 x (0.5*0.25) + 0.125 = 1.125
      fill(16'h1000, 16'h0800);
      run8(16'h0400, 0, 0, 8);
      wait_res(0, 16'h2400, 0, 1, "nominal");

      // floor truncation: 3*8191>>13 = 2, -3*8191>>>13 = -3; 4*(2-3)+5 = 1
      for (int i = 0; i < 8; i++) begin
         xv[i] = (i % 2 == 0) ? 16'h0003 : 16'hFFFD;
         wv[i] = 16'h1FFF;
      end
      run8(16'h0005, 0, 0, 8);
      wait_res(0, 16'h0001, 0, 1, "floor_mix");

      // negative: 8 x (-0.5*0.5) - 0.125 = -2.125 -> -17408
      fill(16'hF000, 16'h1000);
      run8(16'hFC00, 0, 0, 8);
      wait_res(0, 16'hBC00, 0, 1, "negative");

      // sum overflow: 8 x 28672 = 229376
      fill(16'h7000, 16'h2000);
      run8(16'h0000, 0, 0, 8);
      wait_res(0, SUM_OVF_EXP, 1, 1, "sum_ovf");

      // negative sum overflow: -229376 (clamps or wraps to 0x8000 either way)
      fill(16'h9000, 16'h2000);
      run8(16'h0000, 0, 0, 8);
      wait_res(0, 16'h8000, 1, 1, "neg_sum_ovf");

      // product overflow in the first pair only
      fill(16'h0000, 16'h0000);
      xv[0] = 16'h8000;
      wv[0] = 16'h8000;
      run8(16'h0000, 0, 0, 8);
      wait_res(0, PROD_OVF_EXP, 1, 1, "prod_ovf8");

      // flow control: garbage pair at START, random gaps, START pulse mid-ACCUM
      fill(16'h1000, 16'h0800);
      hs0 = hs8;
      vo0 = vo8;
      run8(16'h0400, 1, 1, 8);
      wait_res(0, 16'h2400, 0, 0, "flow");
      repeat (4) @(negedge clk);
      chk("flow_handshakes", 16'(hs8 - hs0), 16'd8);
      chk("flow_valid_count", 16'(vo8 - vo0), 16'd1);

      // reset after 3 accepted pairs aborts the evaluation
      hs0 = hs8;
      vo0 = vo8;
      run8(16'h0400, 0, 0, 3);
      chk("abort_handshakes", 16'(hs8 - hs0), 16'd3);
      rstn = 1'b0;
      @(negedge clk);
      chk("abort_ready", 16'(bus8.READY_OUT), 16'h0000);
      chk("abort_valid", 16'(bus8.VALID_OUT), 16'h0000);
      chk("abort_value", bus8.VALUE_OUT, 16'h0000);
      chk("abort_ovf", 16'(bus8.OVERFLOW), 16'h0000);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_valid", 16'(vo8 - vo0), 16'd0);
      run8(16'h0400, 0, 0, 8);
      wait_res(0, 16'h2400, 0, 1, "after_reset");

      // single-input instance
      run1(16'h0000, 16'hE000, 16'h0001);
      wait_res(1, 16'hFFFF, 0, 1, "round1");
      run1(16'h0000, 16'h8000, 16'h8000);
      wait_res(1, PROD_OVF_EXP, 1, 1, "prod_ovf1");

      // pairs offered while idle are ignored and the result holds
      bus1.X_IN = 16'h1000;
      bus1.W_IN = 16'h1000;
      bus1.VALID_IN = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ready1", 16'(bus1.READY_OUT), 16'h0000);
      chk("hold_value1", bus1.VALUE_OUT, PROD_OVF_EXP);
      chk("hold_ovf1", 16'(bus1.OVERFLOW), 16'h0001);
      bus1.VALID_IN = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fixed_point_neuron_mac.md
FIXED_POINT_NEURON_MAC -- requirements
Module: fixed_point_neuron_mac

Interface
REQ-001 Parameter WIDTH, default 16, signed two's-complement data width.
REQ-002 Parameter FRAC_BITS, default 13, number of fractional bits.
REQ-003 Parameter NUM_INPUTS, default 8, operand pairs per neuron evaluation; legal range 1..256.
REQ-004 CLK  input  1  clock; all state SHALL change on the rising edge only.
REQ-005 RSTN  input  1  reset, synchronous, active-low.
REQ-006 START  input  1  begins one evaluation; sampled only in IDLE.
REQ-007 BIAS_IN  input  WIDTH  signed bias; latched on the cycle START is accepted.
REQ-008 X_IN  input  WIDTH  signed activation operand.
REQ-009 W_IN  input  WIDTH  signed weight operand.
REQ-010 VALID_IN  input  1  X_IN/W_IN pair valid.
REQ-011 READY_OUT  output  1  pair is accepted when VALID_IN and READY_OUT are both high.
REQ-012 VALUE_OUT  output  WIDTH  signed neuron pre-activation sum; feeds the activation-function VALUE_IN.
REQ-013 VALID_OUT  output  1  single-cycle result strobe; feeds the activation-function VALID_IN.
REQ-014 OVERFLOW  output  1  sticky overflow flag.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and BIAS.
REQ-016 In IDLE with START=1, the block SHALL latch BIAS_IN, clear the accumulator, clear the pair counter and OVERFLOW, and enter ACCUM.
REQ-017 The block SHALL drive READY_OUT high only in ACCUM, and the signal SHALL be registered.
REQ-018 Each accepted pair SHALL add its product to the accumulator and increment the pair counter on that edge.
REQ-019 Pairs presented with READY_OUT low SHALL be ignored, and gaps in VALID_IN SHALL stall the block without any effect on state.
REQ-020 When the NUM_INPUTS-th pair is accepted, the block SHALL enter BIAS, with READY_OUT low from the next cycle.
REQ-021 In BIAS, the block SHALL compute accumulator plus bias and narrow it per REQ-025, register the result into VALUE_OUT, pulse VALID_OUT for exactly one cycle, and return to IDLE.
REQ-022 Latency: if the last pair is accepted on edge T, VALID_OUT SHALL be high during the cycle following edge T+1.
REQ-023 START in ACCUM or BIAS SHALL be ignored, and VALUE_OUT SHALL hold the last result until the next VALID_OUT.
REQ-024 Each product SHALL be the full 2*WIDTH-bit X_IN*W_IN arithmetic-shifted right by FRAC_BITS (truncation toward minus infinity), then narrowed to WIDTH bits per REQ-025.
REQ-025 Narrowing SHALL work as follows: a value outside the WIDTH-bit signed range sets OVERFLOW; the result is clamped or wrapped per REQ-030/031.
REQ-026 The accumulator SHALL be WIDTH+clog2(NUM_INPUTS+1)+1 bits wide, so that it never overflows internally.
REQ-027 OVERFLOW SHALL stay set until the next accepted START or reset.

Reset
REQ-028 While RSTN=0 at an edge, the block SHALL enter IDLE and clear the accumulator, counter and latched bias, and drive READY_OUT=0, VALID_OUT=0, VALUE_OUT=0 and OVERFLOW=0.
REQ-029 If reset is asserted during ACCUM or BIAS, the evaluation SHALL be aborted and no VALID_OUT SHALL follow.

Configuration
REQ-030 With macro FIXED_POINT_NEURON_SATURATION_EN defined, an out-of-range value SHALL clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
REQ-031 With the macro undefined, an out-of-range value SHALL wrap (keep the low WIDTH bits); OVERFLOW behaviour is identical in both cases.

Verification
REQ-032 Nominal case: defaults, 8 pairs with X=4096 (0.5) and W=2048 (0.25), BIAS=1024 -> VALUE_OUT=9216 (0x2400), VALID_OUT one cycle, OVERFLOW=0.
REQ-033 Rounding: X=-8192, W=1, NUM_INPUTS=1, BIAS=0 -> VALUE_OUT=-1 (0xFFFF).
REQ-034 Sum overflow: 8 pairs with X=28672 and W=8192, BIAS=0 -> OVERFLOW=1; VALUE_OUT=32767 (0x7FFF) with SATURATION_EN, and -32768 (0x8000) without.
REQ-035 Product overflow: X=-32768, W=-32768, NUM_INPUTS=1, BIAS=0 -> OVERFLOW=1; VALUE_OUT=0x7FFF with SATURATION_EN, and 0x0000 without.
REQ-036 Flow control: random VALID_IN gaps plus a START pulse mid-ACCUM -> same result as the nominal case, exactly one VALID_OUT, exactly NUM_INPUTS handshakes.
REQ-037 Reset: RSTN=0 after 3 accepted pairs -> all outputs 0 next cycle and no VALID_OUT; a subsequent nominal run -> 0x2400.
